// File: rtl/dm_wait_resp.sv
// dm_wait_resp: data-memory responder with a programmable wait-state count,
// req/ready handshake, byte-masked writes and an address range check.
module dm_wait_resp #(
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic [31:0]       r_mem [DEPTH];
    logic              w_go, w_oor, w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic [3:0]        w_be;
    always_comb begin
        w_next = r_state == S_IDLE ? (req ? (WAIT_CYC > 0 ? S_WAIT : S_RESP) : S_IDLE)
               : r_state == S_WAIT ? (r_cnt <= 4'd1 ? S_RESP : S_WAIT)
               : S_IDLE;
    end
    // With zero wait states the access completes on the accepting edge, so use the live inputs
    assign w_we    = r_state == S_IDLE ? we    : r_we;
    assign w_addr  = r_state == S_IDLE ? addr  : r_addr;
    assign w_wdata = r_state == S_IDLE ? wdata : r_wdata;
    assign w_be    = r_state == S_IDLE ? be    : r_be;
    assign w_go    = w_next == S_RESP && r_state != S_RESP;
    assign w_oor   = {{(32-ADDR_W){1'b0}}, w_addr} >= 32'(DEPTH);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            ready   <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= r_state == S_IDLE && req ? 4'(WAIT_CYC) : r_state == S_WAIT ? r_cnt - 4'd1 : r_cnt;
            if (r_state == S_IDLE && req) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_be    <= be;
            end
            ready <= w_next == S_RESP;
            err   <= w_go && w_oor;
            if (w_go && !w_we)
                rdata <= w_oor ? 32'd0 : r_mem[w_addr];
        end
    end
    // Array is never reset; the rst term keeps an aborted access from committing
    always_ff @(posedge clk) begin
        if (rst && w_go && w_we && !w_oor)
            for (int i = 0; i < 4; i++)
                if (w_be[i]) r_mem[w_addr][8*i +: 8] <= w_wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_dm_wait_resp.sv
// tb_dm_wait_resp: directed checks on three responder instances
// (2 waits / DEPTH 1000, zero waits, 5 waits).
module tb_dm_wait_resp;
    logic        clk = 1'b0;
    logic        rst;
    logic        req   [3];
    logic        we    [3];
    logic [9:0]  addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  be    [3];
    logic        ready [3];
    logic [31:0] rdata [3];
    logic        err   [3];
    int          total = 0;
    int          bad   = 0;
    int          lat;

    always #5 clk = ~clk;

    dm_wait_resp #(.ADDR_W(10), .DEPTH(1000), .WAIT_CYC(2)) u0 (
        .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .be(be[0]), .ready(ready[0]), .rdata(rdata[0]), .err(err[0]));
    dm_wait_resp #(.ADDR_W(10), .DEPTH(1024), .WAIT_CYC(0)) u1 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .be(be[1]), .ready(ready[1]), .rdata(rdata[1]), .err(err[1]));
    dm_wait_resp #(.ADDR_W(10), .DEPTH(1024), .WAIT_CYC(5)) u2 (
        .clk(clk), .rst(rst), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
        .be(be[2]), .ready(ready[2]), .rdata(rdata[2]), .err(err[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one access on instance k; returns negedges from acceptance to ready (0 = timeout)
    task automatic access(input int k, input logic w, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] b, output int l);
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
        l = 0;
        for (int n = 1; n <= 40 && l == 0; n++) begin
            @(negedge clk);
            if (ready[k]) l = n;
        end
        req[k] = 1'b0;
        if (l == 0) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic xfer(input string tag, input int k, input logic w, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] b, input int elat,
                        input logic eerr, input logic chkd, input logic [31:0] ed);
        int l;
        access(k, w, a, d, b, l);
        chk({tag, "_lat"}, 32'(l), 32'(elat));
        chk({tag, "_err"}, 32'(err[k]), 32'(eerr));
        if (chkd) chk({tag, "_rdata"}, rdata[k], ed);
    endtask

    int ea [4] = '{3, 4, 3, 4};
    int idx;

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; be[k] = '0;
        end
        req[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 32'(ready[0]), 32'd0);
            chk("rst_err", 32'(err[0]), 32'd0);
            chk("rst_rdata", rdata[0], 32'd0);
        end
        rst = 1'b1;
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (ready[0]) lat = n;
        end
        req[0] = 1'b0;
        chk("rst_first_lat", 32'(lat), 32'd3);

        xfer("wr5", 0, 1'b1, 10'd5, 32'hDEADBEEF, 4'b1111, 3, 1'b0, 1'b0, 32'd0);
        xfer("rd5", 0, 1'b0, 10'd5, 32'd0, 4'b0000, 3, 1'b0, 1'b1, 32'hDEADBEEF);
        xfer("wr5_be", 0, 1'b1, 10'd5, 32'h00112233, 4'b0101, 3, 1'b0, 1'b0, 32'd0);
        xfer("rd5_be", 0, 1'b0, 10'd5, 32'd0, 4'b0000, 3, 1'b0, 1'b1, 32'hDE11BE33);
        xfer("wr5_be0", 0, 1'b1, 10'd5, 32'hFFFFFFFF, 4'b0000, 3, 1'b0, 1'b1, 32'hDE11BE33);
        xfer("rd5_be0", 0, 1'b0, 10'd5, 32'd0, 4'b0000, 3, 1'b0, 1'b1, 32'hDE11BE33);
        @(negedge clk);
        chk("hold_rdata", rdata[0], 32'hDE11BE33);
        chk("hold_ready", 32'(ready[0]), 32'd0);
        chk("hold_err", 32'(err[0]), 32'd0);

        xfer("wr1000", 0, 1'b1, 10'd1000, 32'hCAFEF00D, 4'b1111, 3, 1'b1, 1'b0, 32'd0);
        xfer("rd5_oor", 0, 1'b0, 10'd5, 32'd0, 4'b0000, 3, 1'b0, 1'b1, 32'hDE11BE33);
        xfer("rd1023", 0, 1'b0, 10'd1023, 32'd0, 4'b0000, 3, 1'b1, 1'b1, 32'd0);
        xfer("wr999", 0, 1'b1, 10'd999, 32'h12345678, 4'b1111, 3, 1'b0, 1'b0, 32'd0);
        xfer("rd999", 0, 1'b0, 10'd999, 32'd0, 4'b0000, 3, 1'b0, 1'b1, 32'h12345678);

        xfer("z_wr3", 1, 1'b1, 10'd3, 32'h000000A5, 4'b1111, 1, 1'b0, 1'b0, 32'd0);
        xfer("z_wr4", 1, 1'b1, 10'd4, 32'h0000005A, 4'b1111, 1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'd3; idx = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(ready[1]), 32'(i % 2));
            if (i % 2 == 1) begin
                chk("b2b_rdata", rdata[1], ea[idx] == 3 ? 32'h000000A5 : 32'h0000005A);
                idx++;
                we[1] = 1'b1; addr[1] = 10'd4; wdata[1] = 32'd0; be[1] = 4'b1111;
            end else begin
                we[1] = 1'b0;
                addr[1] = idx < 4 ? 10'(ea[idx]) : 10'd3;
                req[1] = idx < 4;
            end
        end
        req[1] = 1'b0;
        xfer("z_rd4", 1, 1'b0, 10'd4, 32'd0, 4'b0000, 1, 1'b0, 1'b1, 32'h0000005A);

        xfer("w5_wr7", 2, 1'b1, 10'd7, 32'h00000011, 4'b1111, 6, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 10'd7; wdata[2] = 32'd1; be[2] = 4'b1111;
        @(posedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        req[2] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b1;
            chk("abort_ready", 32'(ready[2]), 32'd0);
        end
        xfer("w5_rd7", 2, 1'b0, 10'd7, 32'd0, 4'b0000, 6, 1'b0, 1'b1, 32'h00000011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
